// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Optional feature macro: FWD_WB_PATH_EN enables the WB-stage forward path (select 101).
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic             stall,
  output logic [2:0]       ex_src1_sig,
  output logic [2:0]       ex_src2_sig,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] SEL_RF  = 3'b100;
  localparam logic [2:0] SEL_MEM = 3'b110;
  localparam logic [2:0] SEL_WB  = 3'b101;
  localparam logic [2:0] SEL_IMM = 3'b000;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } rec_t;

  typedef enum logic {RUN, STALL} state_t;

  rec_t   ex_q, mem_q, wb_q, id_rec;
  state_t state_q, state_d;
  logic   haz1, haz2, hazard;
  logic [2:0] sel1, sel2;

  function automatic logic produces(input rec_t rec, input logic [REG_W-1:0] r);
    return rec.valid && rec.regwrite && (rec.rd == r) && (r != '0);
  endfunction

  // Returns {hazard, select}; the youngest producer (EX) takes priority over MEM.
  function automatic logic [3:0] dep(input rec_t ex, input rec_t mem, input rec_t wb,
                                     input logic [REG_W-1:0] r);
    logic [3:0] res;
    res = {1'b0, SEL_RF};
    if (produces(ex, r) && ex.memread)
      res = {1'b1, SEL_RF};
    else if (produces(ex, r))
      res = {1'b0, SEL_MEM};
    else if (produces(mem, r))
`ifdef FWD_WB_PATH_EN
      res = {1'b0, SEL_WB};
`else
      res = {1'b1, SEL_RF};
`endif
    else if (produces(wb, r))
      res = {1'b0, SEL_RF};  // register file writes through, so WB needs no forward
    return res;
  endfunction

  always_comb begin
    haz1 = 1'b0;
    sel1 = SEL_RF;
    haz2 = 1'b0;
    sel2 = id_use_imm ? SEL_IMM : SEL_RF;
    if (id_use_rs1) {haz1, sel1} = dep(ex_q, mem_q, wb_q, id_rs1);
    if (id_use_rs2) {haz2, sel2} = dep(ex_q, mem_q, wb_q, id_rs2);
    hazard = id_valid && (haz1 || haz2);
    stall  = hazard && !pipe_hold && !RST;
  end

  always_comb begin
    id_rec.valid    = 1'b1;
    id_rec.rd       = id_rd;
    id_rec.regwrite = id_regwrite;
    id_rec.memread  = id_memread;
  end

  always_comb begin
    state_d = state_q;
    if (!pipe_hold) begin
      case (state_q)
        RUN:     if (stall)  state_d = STALL;
        STALL:   if (!stall) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_src1_sig <= SEL_RF;
      ex_src2_sig <= SEL_RF;
      stall_cnt   <= '0;
    end else if (!pipe_hold) begin
      state_q <= state_d;
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      if (id_valid && !stall && !flush) begin
        ex_q        <= id_rec;
        ex_src1_sig <= sel1;
        ex_src2_sig <= sel2;
      end else begin
        ex_q        <= '0;
        ex_src1_sig <= SEL_RF;
        ex_src2_sig <= SEL_RF;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: driver queues per-cycle expectations, negedge monitor checks.
module tb_fwd_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          id_valid, id_use_rs1, id_use_rs2, id_use_imm, id_regwrite, id_memread;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          pipe_hold, flush;
  logic          stall;
  logic [2:0]    ex_src1_sig, ex_src2_sig;
  logic [CW-1:0] stall_cnt;

  fwd_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .pipe_hold(pipe_hold), .flush(flush), .stall(stall),
    .ex_src1_sig(ex_src1_sig), .ex_src2_sig(ex_src2_sig), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic          st;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [CW-1:0] cnt;
    int            mask;  // bit0: check sigs, bit1: check stall_cnt
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk(mon_e.name, "stall", 16'(stall), 16'(mon_e.st));
      if ((mon_e.mask & 1) != 0) begin
        chk(mon_e.name, "src1", 16'(ex_src1_sig), 16'(mon_e.s1));
        chk(mon_e.name, "src2", 16'(ex_src2_sig), 16'(mon_e.s2));
      end
      if ((mon_e.mask & 2) != 0)
        chk(mon_e.name, "cnt", 16'(stall_cnt), 16'(mon_e.cnt));
    end
  end

  task automatic id(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                    input logic imm, input int rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_use_imm = imm;
    id_rd = RW'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();                         id(0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic lw(input int rd, input int rs1); id(1, rs1, 0, 1, 0, 1, rd, 1, 1); endtask
  task automatic alu(input int rd, input int rs1, input int rs2); id(1, rs1, rs2, 1, 1, 0, rd, 1, 0); endtask

  // Expectation for the current cycle: stall now, sigs/count as registered at the previous edge.
  task automatic cyc(input string nm, input logic st, input logic [2:0] s1, input logic [2:0] s2,
                     input int cnt, input int mask = 3);
    exp_t e;
    e.name = nm; e.st = st; e.s1 = s1; e.s2 = s2; e.cnt = CW'(cnt); e.mask = mask;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    RST = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic rst_cycle();
    nop(); RST = 1'b1;
    cyc("rst", 0, 3'b100, 3'b100, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int ec;

  initial begin
    RST = 1'b1; pipe_hold = 1'b0; flush = 1'b0; nop();
    @(posedge CLK); #1;
    RST = 1'b1;
    cyc("reset", 0, 3'b100, 3'b100, 0);

    // add x3<-x1,x2 ; sub x4<-x3,x5
    alu(3, 1, 2); cyc("s1_add", 0, 3'b100, 3'b100, 0);
    alu(4, 3, 5); cyc("s1_sub", 0, 3'b100, 3'b100, 0);
    nop();        cyc("s1_ex",  0, 3'b110, 3'b100, 0);
    rst_cycle();

    // lw x3 ; nop ; add x6<-x3,x3
    lw(3, 1);     cyc("s2_lw",  0, 3'b100, 3'b100, 0);
    nop();        cyc("s2_nop", 0, 3'b100, 3'b000, 0);
`ifdef FWD_WB_PATH_EN
    alu(6, 3, 3); cyc("s2_add", 0, 3'b100, 3'b100, 0);
    nop();        cyc("s2_ex",  0, 3'b101, 3'b101, 0);
`else
    alu(6, 3, 3); cyc("s2_add", 1, 3'b100, 3'b100, 0);
    alu(6, 3, 3); cyc("s2_rel", 0, 3'b100, 3'b100, 1);
    nop();        cyc("s2_ex",  0, 3'b100, 3'b100, 1);
`endif
    rst_cycle();

    // lw x3 ; add x6<-x3,x0
    lw(3, 1);     cyc("s3_lw",  0, 3'b100, 3'b100, 0);
    alu(6, 3, 0); cyc("s3_lu",  1, 3'b100, 3'b000, 0);
`ifdef FWD_WB_PATH_EN
    alu(6, 3, 0); cyc("s3_rel", 0, 3'b100, 3'b100, 1);
    nop();        cyc("s3_ex",  0, 3'b101, 3'b100, 1);
`else
    alu(6, 3, 0); cyc("s3_st2", 1, 3'b100, 3'b100, 1);
    alu(6, 3, 0); cyc("s3_rel", 0, 3'b100, 3'b100, 2);
    nop();        cyc("s3_ex",  0, 3'b100, 3'b100, 2);
`endif
    rst_cycle();

    // two producers of x7, then x0 writes
    alu(7, 1, 2); cyc("s4_p1",  0, 3'b100, 3'b100, 0);
    alu(7, 1, 2); cyc("s4_p2",  0, 3'b100, 3'b100, 0);
    alu(8, 7, 0); cyc("s4_use", 0, 3'b100, 3'b100, 0);
    lw(0, 1);     cyc("s4_lw0", 0, 3'b110, 3'b100, 0);
    alu(9, 0, 0); cyc("s4_x0",  0, 3'b100, 3'b000, 0);
    nop();        cyc("s4_ex",  0, 3'b100, 3'b100, 0);
    rst_cycle();

    // pipe_hold for 3 cycles over a load-use stall, then stall+flush
    lw(3, 1);     cyc("s5_lw",  0, 3'b100, 3'b100, 0);
    for (int i = 0; i < 3; i++) begin
      alu(6, 3, 0); pipe_hold = 1'b1;
      cyc("s5_hold", 0, 3'b100, 3'b000, 0);
    end
    alu(6, 3, 0); flush = 1'b1; cyc("s5_lu", 1, 3'b100, 3'b000, 0);
`ifdef FWD_WB_PATH_EN
    alu(6, 3, 0); cyc("s5_rel", 0, 3'b100, 3'b100, 1);
    nop();        cyc("s5_ex",  0, 3'b101, 3'b100, 1);
`else
    alu(6, 3, 0); cyc("s5_st2", 1, 3'b100, 3'b100, 1);
    alu(6, 3, 0); cyc("s5_rel", 0, 3'b100, 3'b100, 2);
    nop();        cyc("s5_ex",  0, 3'b100, 3'b100, 2);
`endif
    rst_cycle();

    // flushed producer must not be forwarded
    alu(6, 1, 2); flush = 1'b1; cyc("s6_fl", 0, 3'b100, 3'b100, 0);
    alu(11, 6, 6); cyc("s6_use", 0, 3'b100, 3'b100, 0);
    nop();         cyc("s6_ex",  0, 3'b100, 3'b100, 0);
    rst_cycle();

    // saturation with back-to-back load-use pairs
    ec = 0;
    for (int p = 0; p < 9; p++) begin
      lw(3, 1);     cyc("sat_lw", 0, 3'b100, 3'b100, ec, 2);
      alu(6, 3, 0); cyc("sat_lu", 1, 3'b100, 3'b100, ec, 2);
      if (ec < 7) ec++;
`ifndef FWD_WB_PATH_EN
      alu(6, 3, 0); cyc("sat_st2", 1, 3'b100, 3'b100, ec, 2);
      if (ec < 7) ec++;
`endif
      alu(6, 3, 0); cyc("sat_rel", 0, 3'b100, 3'b100, ec, 2);
    end
    lw(3, 1);     cyc("mr_lw", 0, 3'b100, 3'b100, 7, 2);
    alu(6, 3, 0); cyc("mr_lu", 1, 3'b100, 3'b100, 7, 2);
    alu(6, 3, 0); RST = 1'b1; cyc("mr_rst", 0, 3'b100, 3'b100, 7, 2);
    alu(6, 3, 0); cyc("mr_after", 0, 3'b100, 3'b100, 0);
    nop();        cyc("mr_ex",    0, 3'b100, 3'b100, 0);

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge CLK);
    if (sbq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
